// File: rtl/chroma_key_ctrl.sv
// Frame-synchronous configuration controller for the chroma-key datapath.
// Buffers user settings in pending registers and commits them at each frame boundary; also learns a custom key colour.
module chroma_key_ctrl #(
    parameter int WIN_X0     = 312,
    parameter int WIN_Y0     = 232,
    parameter int MARGIN_RST = 2,
    parameter int CAL_TRIES  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic       de,
    input  logic [9:0] x_pixel,
    input  logic [9:0] y_pixel,
    input  logic [3:0] red_cam,
    input  logic [3:0] green_cam,
    input  logic [3:0] blue_cam,
    input  logic       sw_enable,
    input  logic       btn_mode,
    input  logic       btn_margin,
    input  logic       btn_cal,
    output logic       mode_chroma,
    output logic [1:0] key_sel,
    output logic [3:0] key_r,
    output logic [3:0] key_g,
    output logic [3:0] key_b,
    output logic [2:0] margin,
    output logic       cal_busy,
    output logic       cal_done,
    output logic       cal_fail
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_ACCUM} state_t;

    localparam logic [9:0] X_LO        = 10'(WIN_X0);
    localparam logic [9:0] X_HI        = 10'(WIN_X0 + 15);
    localparam logic [9:0] Y_LO        = 10'(WIN_Y0);
    localparam logic [9:0] Y_HI        = 10'(WIN_Y0 + 15);
    localparam logic [2:0] MARGIN_INIT = 3'(MARGIN_RST);
    localparam logic [3:0] TRIES_MAX   = 4'(CAL_TRIES);

    state_t      state_q, state_d;
    logic        vsync_q;
    logic        fb;
    logic        in_win;
    logic        sample;

    logic        pend_en_q;
    logic [1:0]  pend_sel_q, pend_sel_d;
    logic [3:0]  pend_r_q, pend_r_d, pend_g_q, pend_g_d, pend_b_q, pend_b_d;
    logic [2:0]  pend_margin_q, pend_margin_d;

    logic        mode_q, mode_d;
    logic [1:0]  sel_q, sel_d;
    logic [3:0]  key_r_q, key_r_d, key_g_q, key_g_d, key_b_q, key_b_d;
    logic [2:0]  margin_q, margin_d;
    logic        cal_done_q, cal_done_d;
    logic        cal_fail_q, cal_fail_d;

    logic [11:0] sum_r_q, sum_r_d, sum_g_q, sum_g_d, sum_b_q, sum_b_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [3:0]  tries_q, tries_d;

    assign fb     = vsync & ~vsync_q;
    assign in_win = de && (x_pixel >= X_LO) && (x_pixel <= X_HI) &&
                    (y_pixel >= Y_LO) && (y_pixel <= Y_HI);
    // Count stops at 256 so a repeated window cannot overflow the 12-bit sums.
    assign sample = (state_q == S_ACCUM) && in_win && !cnt_q[8];

    always_comb begin
        state_d       = state_q;
        pend_sel_d    = pend_sel_q;
        pend_r_d      = pend_r_q;
        pend_g_d      = pend_g_q;
        pend_b_d      = pend_b_q;
        pend_margin_d = pend_margin_q;
        mode_d        = mode_q;
        sel_d         = sel_q;
        key_r_d       = key_r_q;
        key_g_d       = key_g_q;
        key_b_d       = key_b_q;
        margin_d      = margin_q;
        cal_done_d    = 1'b0;
        cal_fail_d    = 1'b0;
        sum_r_d       = sum_r_q;
        sum_g_d       = sum_g_q;
        sum_b_d       = sum_b_q;
        cnt_d         = cnt_q;
        tries_d       = tries_q;

        if (btn_mode && state_q == S_IDLE) begin
            unique case (pend_sel_q)
                2'd0:    begin pend_sel_d = 2'd1; pend_r_d = 4'd0; pend_g_d = 4'd0;  pend_b_d = 4'd15; end
                2'd1:    begin pend_sel_d = 2'd2; pend_r_d = 4'd0; pend_g_d = 4'd0;  pend_b_d = 4'd0;  end
                default: begin pend_sel_d = 2'd0; pend_r_d = 4'd0; pend_g_d = 4'd15; pend_b_d = 4'd0;  end
            endcase
        end
        if (btn_margin) begin
            pend_margin_d = pend_margin_q + 3'd1;
        end

        // Commit uses the pending values registered before this edge, so a
        // coincident button lands one frame later.
        if (fb) begin
            mode_d   = pend_en_q;
            sel_d    = pend_sel_q;
            key_r_d  = pend_r_q;
            key_g_d  = pend_g_q;
            key_b_d  = pend_b_q;
            margin_d = pend_margin_q;
        end

        if (sample) begin
            sum_r_d = sum_r_q + {8'd0, red_cam};
            sum_g_d = sum_g_q + {8'd0, green_cam};
            sum_b_d = sum_b_q + {8'd0, blue_cam};
            cnt_d   = cnt_q + 9'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (btn_cal) begin
                    state_d = S_ARM;
                    tries_d = 4'd0;
                end
            end
            S_ARM: begin
                if (fb) begin
                    sum_r_d = 12'd0;
                    sum_g_d = 12'd0;
                    sum_b_d = 12'd0;
                    cnt_d   = 9'd0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (fb) begin
                    if (cnt_q == 9'd256) begin
                        // Top nibble of a 256-sample sum is the mean.
                        pend_sel_d = 2'd3;
                        pend_r_d   = sum_r_q[11:8];
                        pend_g_d   = sum_g_q[11:8];
                        pend_b_d   = sum_b_q[11:8];
                        sel_d      = 2'd3;
                        key_r_d    = sum_r_q[11:8];
                        key_g_d    = sum_g_q[11:8];
                        key_b_d    = sum_b_q[11:8];
                        cal_done_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        sum_r_d = 12'd0;
                        sum_g_d = 12'd0;
                        sum_b_d = 12'd0;
                        cnt_d   = 9'd0;
                        tries_d = tries_q + 4'd1;
                        if (tries_q + 4'd1 == TRIES_MAX) begin
                            cal_fail_d = 1'b1;
                            state_d    = S_IDLE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            vsync_q       <= 1'b0;
            pend_en_q     <= 1'b0;
            pend_sel_q    <= 2'd0;
            pend_r_q      <= 4'd0;
            pend_g_q      <= 4'd15;
            pend_b_q      <= 4'd0;
            pend_margin_q <= MARGIN_INIT;
            mode_q        <= 1'b0;
            sel_q         <= 2'd0;
            key_r_q       <= 4'd0;
            key_g_q       <= 4'd15;
            key_b_q       <= 4'd0;
            margin_q      <= MARGIN_INIT;
            cal_done_q    <= 1'b0;
            cal_fail_q    <= 1'b0;
            sum_r_q       <= 12'd0;
            sum_g_q       <= 12'd0;
            sum_b_q       <= 12'd0;
            cnt_q         <= 9'd0;
            tries_q       <= 4'd0;
        end else begin
            state_q       <= state_d;
            vsync_q       <= vsync;
            pend_en_q     <= sw_enable;
            pend_sel_q    <= pend_sel_d;
            pend_r_q      <= pend_r_d;
            pend_g_q      <= pend_g_d;
            pend_b_q      <= pend_b_d;
            pend_margin_q <= pend_margin_d;
            mode_q        <= mode_d;
            sel_q         <= sel_d;
            key_r_q       <= key_r_d;
            key_g_q       <= key_g_d;
            key_b_q       <= key_b_d;
            margin_q      <= margin_d;
            cal_done_q    <= cal_done_d;
            cal_fail_q    <= cal_fail_d;
            sum_r_q       <= sum_r_d;
            sum_g_q       <= sum_g_d;
            sum_b_q       <= sum_b_d;
            cnt_q         <= cnt_d;
            tries_q       <= tries_d;
        end
    end

    assign mode_chroma = mode_q;
    assign key_sel     = sel_q;
    assign key_r       = key_r_q;
    assign key_g       = key_g_q;
    assign key_b       = key_b_q;
    assign margin      = margin_q;
    assign cal_busy    = (state_q != S_IDLE);
    assign cal_done    = cal_done_q;
    assign cal_fail    = cal_fail_q;

endmodule

// File: tb/tb_chroma_key_ctrl.sv
// Bench for chroma_key_ctrl: randomized button/pixel stimulus against a frame-level reference model.
module tb_chroma_key_ctrl;

    localparam int WIN_X0 = 312;
    localparam int WIN_Y0 = 232;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       vsync = 1'b0;
    logic       de = 1'b0;
    logic [9:0] x_pixel = '0;
    logic [9:0] y_pixel = '0;
    logic [3:0] red_cam = '0, green_cam = '0, blue_cam = '0;
    logic       sw_enable = 1'b0;
    logic       btn_mode = 1'b0, btn_margin = 1'b0, btn_cal = 1'b0;
    logic       mode_chroma;
    logic [1:0] key_sel;
    logic [3:0] key_r, key_g, key_b;
    logic [2:0] margin;
    logic       cal_busy, cal_done, cal_fail;

    chroma_key_ctrl #(.WIN_X0(WIN_X0), .WIN_Y0(WIN_Y0), .MARGIN_RST(2), .CAL_TRIES(4)) dut (
        .clk(clk), .reset(reset), .vsync(vsync), .de(de),
        .x_pixel(x_pixel), .y_pixel(y_pixel),
        .red_cam(red_cam), .green_cam(green_cam), .blue_cam(blue_cam),
        .sw_enable(sw_enable), .btn_mode(btn_mode), .btn_margin(btn_margin), .btn_cal(btn_cal),
        .mode_chroma(mode_chroma), .key_sel(key_sel),
        .key_r(key_r), .key_g(key_g), .key_b(key_b), .margin(margin),
        .cal_busy(cal_busy), .cal_done(cal_done), .cal_fail(cal_fail)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: pending (p_) and committed (c_) settings, calibration progress per frame.
    logic       p_en, c_en;
    logic [1:0] p_sel, c_sel;
    logic [3:0] p_kr, p_kg, p_kb, c_kr, c_kg, c_kb;
    int         p_mg, c_mg;
    int         st;          // 0 idle, 1 waiting for first frame, 2 averaging
    int         tries, cnt, sr, sg, sb;
    logic       exp_done, exp_fail;

    wire [20:0] dut_vec = {mode_chroma, key_sel, key_r, key_g, key_b, margin, cal_busy, cal_done, cal_fail};

    function automatic logic [20:0] exp_vec();
        return {c_en, c_sel, c_kr, c_kg, c_kb, 3'(c_mg), (st != 0), exp_done, exp_fail};
    endfunction

    function automatic void model_reset();
        p_en = 1'b0; c_en = 1'b0;
        p_sel = 2'd0; c_sel = 2'd0;
        p_kr = 4'd0; p_kg = 4'd15; p_kb = 4'd0;
        c_kr = 4'd0; c_kg = 4'd15; c_kb = 4'd0;
        p_mg = 2; c_mg = 2;
        st = 0; tries = 0; cnt = 0; sr = 0; sg = 0; sb = 0;
        exp_done = 1'b0; exp_fail = 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_mode();
        btn_mode = 1'b1; tick(); btn_mode = 1'b0;
        if (st == 0) begin
            p_sel = (p_sel == 2'd0) ? 2'd1 : (p_sel == 2'd1) ? 2'd2 : 2'd0;
            p_kr = 4'd0;
            p_kg = (p_sel == 2'd0) ? 4'd15 : 4'd0;
            p_kb = (p_sel == 2'd1) ? 4'd15 : 4'd0;
        end
    endtask

    task automatic press_margin();
        btn_margin = 1'b1; tick(); btn_margin = 1'b0;
        p_mg = (p_mg + 1) % 8;
    endtask

    task automatic press_cal();
        btn_cal = 1'b1; tick(); btn_cal = 1'b0;
        if (st == 0) begin st = 1; tries = 0; end
    endtask

    task automatic set_sw(input logic v);
        sw_enable = v; p_en = v; tick();
    endtask

    // One blanking cycle, then a one-cycle vsync pulse (the frame boundary).
    task automatic vs_pulse(input bit with_margin);
        de = 1'b0; vsync = 1'b0; tick();
        vsync = 1'b1; btn_margin = with_margin; tick();
        vsync = 1'b0; btn_margin = 1'b0;
        exp_done = 1'b0; exp_fail = 1'b0;
        c_en = p_en; c_sel = p_sel; c_kr = p_kr; c_kg = p_kg; c_kb = p_kb; c_mg = p_mg;
        if (st == 1) begin
            st = 2; cnt = 0; sr = 0; sg = 0; sb = 0;
        end else if (st == 2) begin
            if (cnt == 256) begin
                p_sel = 2'd3; c_sel = 2'd3;
                p_kr = 4'(sr / 256); p_kg = 4'(sg / 256); p_kb = 4'(sb / 256);
                c_kr = p_kr; c_kg = p_kg; c_kb = p_kb;
                exp_done = 1'b1; st = 0;
            end else begin
                tries++; cnt = 0; sr = 0; sg = 0; sb = 0;
                if (tries == 4) begin exp_fail = 1'b1; st = 0; end
            end
        end
        if (with_margin) p_mg = (p_mg + 1) % 8;
    endtask

    task automatic drive_pix(input int x, input int y, input logic d, input logic [3:0] r, g, b);
        x_pixel = 10'(x); y_pixel = 10'(y); de = d;
        red_cam = r; green_cam = g; blue_cam = b;
        tick();
        if (d && st == 2 && x >= WIN_X0 && x <= WIN_X0 + 15 && y >= WIN_Y0 && y <= WIN_Y0 + 15 && cnt < 256) begin
            cnt++; sr += r; sg += g; sb += b;
        end
    endtask

    // Window pixels plus out-of-window and de-low decoys with random colours.
    task automatic pix_frame(input logic de_win, input bit uniform, input logic [3:0] ur, ug, ub);
        drive_pix(WIN_X0 - 1,  WIN_Y0,      1'b1, 4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)));
        drive_pix(WIN_X0 + 16, WIN_Y0 + 3,  1'b1, 4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)));
        drive_pix(WIN_X0 + 5,  WIN_Y0 - 1,  1'b1, 4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)));
        drive_pix(WIN_X0 + 5,  WIN_Y0 + 16, 1'b1, 4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)));
        for (int yy = 0; yy < 16; yy++) begin
            drive_pix(WIN_X0, WIN_Y0 + yy, 1'b0, 4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)));
            for (int xx = 0; xx < 16; xx++) begin
                if (uniform)
                    drive_pix(WIN_X0 + xx, WIN_Y0 + yy, de_win, ur, ug, ub);
                else
                    drive_pix(WIN_X0 + xx, WIN_Y0 + yy, de_win,
                              4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)));
            end
        end
        de = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        tick(); tick();
        n_checks++;
        if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL reset_values: got %h expected %h", dut_vec, exp_vec()); end
        reset = 1'b0;
        tick();
        vs_pulse(0);
        n_checks++;
        if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL first_fb_defaults: got %h expected %h", dut_vec, exp_vec()); end
    endtask

    task automatic test_enable_mode();
        set_sw(1'b1);
        press_mode(); press_mode();
        repeat (3) tick();
        n_checks++;
        if (dut_vec !== {1'b0, 2'd0, 4'd0, 4'd15, 4'd0, 3'd2, 3'b000}) begin
            n_fail++; $display("FAIL pending_held: got %h expected %h", dut_vec, {1'b0, 2'd0, 4'd0, 4'd15, 4'd0, 3'd2, 3'b000});
        end
        vs_pulse(0);
        n_checks++;
        if (dut_vec !== {1'b1, 2'd2, 4'd0, 4'd0, 4'd0, 3'd2, 3'b000}) begin
            n_fail++; $display("FAIL enable_black_commit: got %h expected %h", dut_vec, {1'b1, 2'd2, 4'd0, 4'd0, 4'd0, 3'd2, 3'b000});
        end
        for (int i = 0; i < 4; i++) begin
            int np;
            np = $urandom_range(4);
            repeat (np) press_mode();
            set_sw(1'($urandom_range(1)));
            n_checks++;
            if (mode_chroma !== c_en || key_sel !== c_sel) begin
                n_fail++; $display("FAIL mode_before_fb[%0d]: got %b/%0d expected %b/%0d", i, mode_chroma, key_sel, c_en, c_sel);
            end
            vs_pulse(0);
            n_checks++;
            if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL random_mode[%0d]: got %h expected %h", i, dut_vec, exp_vec()); end
        end
    endtask

    task automatic test_margin();
        repeat (9) press_margin();
        vs_pulse(0);
        n_checks++;
        if (margin !== 3'd3) begin n_fail++; $display("FAIL margin_wrap: got %0d expected 3", margin); end
        vs_pulse(1);
        n_checks++;
        if (dut_vec !== exp_vec() || margin !== 3'd3) begin n_fail++; $display("FAIL margin_coincident: got %h expected %h", dut_vec, exp_vec()); end
        vs_pulse(0);
        n_checks++;
        if (margin !== 3'd4) begin n_fail++; $display("FAIL margin_next_frame: got %0d expected 4", margin); end
    endtask

    task automatic test_vsync_hold();
        de = 1'b0; vsync = 1'b0; tick();
        vsync = 1'b1; tick();
        c_en = p_en; c_sel = p_sel; c_kr = p_kr; c_kg = p_kg; c_kb = p_kb; c_mg = p_mg;
        press_margin();
        press_mode();
        repeat (5) tick();
        n_checks++;
        if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL vsync_held_single_fb: got %h expected %h", dut_vec, exp_vec()); end
        vsync = 1'b0;
        vs_pulse(0);
        n_checks++;
        if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL after_vsync_hold: got %h expected %h", dut_vec, exp_vec()); end
    endtask

    task automatic test_cal_uniform();
        press_cal();
        n_checks++;
        if (cal_busy !== 1'b1) begin n_fail++; $display("FAIL cal_busy_set: got %b expected 1", cal_busy); end
        vs_pulse(0);
        press_mode();
        press_cal();
        pix_frame(1'b1, 1'b1, 4'd3, 4'd12, 4'd5);
        n_checks++;
        if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL cal_accum_stable: got %h expected %h", dut_vec, exp_vec()); end
        vs_pulse(0);
        n_checks++;
        if (dut_vec !== exp_vec() || {key_r, key_g, key_b} !== {4'd3, 4'd12, 4'd5} || cal_done !== 1'b1) begin
            n_fail++; $display("FAIL cal_uniform_commit: got %h expected %h", dut_vec, exp_vec());
        end
        exp_done = 1'b0;
        tick();
        n_checks++;
        if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL cal_done_one_cycle: got %h expected %h", dut_vec, exp_vec()); end
    endtask

    task automatic test_cal_random();
        press_cal();
        vs_pulse(0);
        press_margin();
        set_sw(~sw_enable);
        pix_frame(1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
        vs_pulse(0);
        n_checks++;
        if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL cal_random_commit: got %h expected %h", dut_vec, exp_vec()); end
        exp_done = 1'b0;
        press_mode();
        vs_pulse(0);
        n_checks++;
        if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL custom_to_green: got %h expected %h", dut_vec, exp_vec()); end
    endtask

    task automatic test_cal_fail();
        press_mode();
        vs_pulse(0);
        press_cal();
        vs_pulse(0);
        for (int f = 0; f < 4; f++) begin
            pix_frame(1'b0, 1'b1, 4'd7, 4'd7, 4'd7);
            vs_pulse(0);
            n_checks++;
            if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL cal_fail_frame[%0d]: got %h expected %h", f, dut_vec, exp_vec()); end
        end
        exp_fail = 1'b0;
        tick();
        n_checks++;
        if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL cal_fail_one_cycle: got %h expected %h", dut_vec, exp_vec()); end
    endtask

    task automatic test_reset_mid_cal();
        press_margin();
        press_cal();
        vs_pulse(0);
        for (int i = 0; i < 40; i++)
            drive_pix(WIN_X0 + (i % 16), WIN_Y0 + (i / 16), 1'b1, 4'd9, 4'd9, 4'd9);
        sw_enable = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL async_reset_mid_cal: got %h expected %h", dut_vec, exp_vec()); end
        tick();
        reset = 1'b0;
        tick();
        vs_pulse(0);
        vs_pulse(0);
        n_checks++;
        if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL no_pulse_after_reset: got %h expected %h", dut_vec, exp_vec()); end
        press_cal();
        vs_pulse(0);
        pix_frame(1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
        vs_pulse(0);
        n_checks++;
        if (dut_vec !== exp_vec() || cal_done !== 1'b1) begin n_fail++; $display("FAIL cal_after_reset: got %h expected %h", dut_vec, exp_vec()); end
    endtask

    initial begin
        test_reset();
        test_enable_mode();
        test_margin();
        test_vsync_hold();
        test_cal_uniform();
        test_cal_random();
        test_cal_fail();
        test_reset_mid_cal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/chroma_key_ctrl.md
Name: chroma_key_ctrl

Overview:
- Frame-synchronous configuration controller for the chroma-key pixel datapath.
- Turns user pulses (key colour select, margin step, calibrate) and the enable switch into stable per-frame config: mode_chroma, key colour, margin.
- Runs a calibration FSM that learns a custom key colour by averaging a 16x16 window of camera pixels over one frame.
- Sits between the debounced button/switch logic and the chroma-key datapath. All config outputs change only at a frame boundary, so no frame is ever keyed with mixed settings.

Parameters:
WIN_X0, 312, left column of the 16x16 calibration window
WIN_Y0, 232, top row of the 16x16 calibration window
MARGIN_RST, 2, margin value loaded at reset (0..7)
CAL_TRIES, 4, frames attempted before calibration gives up (1..15)

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-high reset
vsync  in  1  active-high vertical sync; a rising edge marks the frame boundary
de  in  1  display-enable, pixel valid
x_pixel  in  10  current pixel column
y_pixel  in  10  current pixel row
red_cam  in  4  camera pixel red
green_cam  in  4  camera pixel green
blue_cam  in  4  camera pixel blue
sw_enable  in  1  chroma-key enable switch (level)
btn_mode  in  1  one-cycle pulse: next key preset
btn_margin  in  1  one-cycle pulse: margin step
btn_cal  in  1  one-cycle pulse: start calibration
mode_chroma  out  1  keying enable to the datapath
key_sel  out  2  0 GREEN, 1 BLUE, 2 BLACK, 3 CUSTOM
key_r  out  4  key colour red
key_g  out  4  key colour green
key_b  out  4  key colour blue
margin  out  3  compare margin to the datapath
cal_busy  out  1  calibration in progress
cal_done  out  1  one-cycle pulse: calibration committed
cal_fail  out  1  one-cycle pulse: calibration abandoned

Behaviour:
- Reset is asynchronous and active-high on reset; clock is clk.
- Reset values: mode_chroma=0, key_sel=0, key=(0,15,0), margin=MARGIN_RST, cal_busy=0, cal_done=0, cal_fail=0, FSM=IDLE.
- Frame boundary (fb):
  - vsync is registered into vsync_d; fb = vsync & ~vsync_d.
  - Committed outputs update on the clk edge where fb=1 and are visible the following cycle.
- Pending registers: pend_en, pend_sel, pend_margin, pend_key. Button pulses modify only pending registers. Every fb copies pending into outputs.
- pend_en follows sw_enable every cycle.
- btn_mode advances pend_sel 0->1->2->0; from 3 it goes to 0. pend_key loads the preset: GREEN (0,15,0), BLUE (0,0,15), BLACK (0,0,0).
- btn_margin: pend_margin+1, wrapping 7->0.
- Button and fb in the same cycle: the button updates pending; the commit uses the old pending value. The change appears at the next fb.
- Calibration FSM (states IDLE, ARM, ACCUM):
  - IDLE:
    - btn_cal -> ARM, cal_busy=1, try counter=0.
  - ARM:
    - At fb: clear sums and pixel count -> ACCUM.
  - ACCUM:
    - A pixel is sampled when de=1, WIN_X0<=x<=WIN_X0+15 and WIN_Y0<=y<=WIN_Y0+15.
    - Each sample adds 4-bit channels into 12-bit sums. The 9-bit count saturates at 256.
    - At the next fb with count==256:
      - pend_key = (sum_r[11:8], sum_g[11:8], sum_b[11:8]); pend_sel=3.
      - These values are committed on that same fb edge, bypassing the pending path.
      - cal_done pulses for 1 cycle; -> IDLE, cal_busy=0.
    - At fb with count<256 (window clipped or de missing):
      - Increment the try counter, clear the accumulators and stay in ACCUM.
      - If tries reaches CAL_TRIES: cal_fail pulses, previous key is unchanged, -> IDLE.
- While cal_busy=1, btn_mode and btn_cal are ignored. btn_margin and sw_enable still act.
- mode_chroma stays at its committed value during calibration; calibration does not force keying off.
- Reset mid-calibration returns to IDLE with defaults. No cal_done or cal_fail is emitted.
- If vsync is held high, only one fb occurs. If vsync never toggles, the FSM waits in ARM/ACCUM indefinitely.

Test Plan:
- Reset, then toggle vsync -> after the first fb: mode_chroma=0, key_sel=0, key=(0,15,0), margin=2.
- sw_enable=1 mid-frame -> mode_chroma stays 0 until the cycle after the next fb, then 1. btn_mode x2 -> key_sel=2, key=(0,0,0) only after the next fb.
- btn_margin x9 -> margin reads 3 after fb (wraps 7->0). btn_margin coincident with the fb cycle -> value appears one frame later.
- btn_cal, then a frame where all window pixels are (3,12,5) -> at the end-of-frame fb: key=(3,12,5), key_sel=3, one-cycle cal_done, cal_busy=0. btn_mode pulsed during ACCUM is ignored.
- btn_cal with de forced low inside the window for 4 frames -> cal_fail pulses at the 4th fb; key and key_sel unchanged, cal_busy=0.
- Assert reset during ACCUM -> all outputs at reset values, no cal_done or cal_fail pulse. A subsequent btn_cal calibration completes normally.
